// File: rtl/uart_rx_ctrl.sv
// UART 8N1 receive controller. It sequences an external 8-bit SIPO register,
// latches the completed byte, and hands it off on a valid/ready interface.
module uart_rx_ctrl #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clk_i,
  input  logic       reset_ni,
  input  logic       rx_in_i,
  input  logic [7:0] sipo_q_i,
  output logic       sipo_shift_o,
  output logic       sipo_bit_o,
  output logic       sipo_clr_o,
  output logic [7:0] data_out_o,
  output logic       rx_valid_o,
  input  logic       rx_ready_i,
  output logic       frame_err_o,
  output logic       overrun_err_o,
  output logic       busy_o
);

  localparam int TW = $clog2(CLKS_PER_BIT);
  localparam logic [TW-1:0] HALF_RELOAD = TW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [TW-1:0] FULL_RELOAD = TW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK
  } state_e;

  state_e        state_q, state_d;
  logic [1:0]    sync_q;
  logic          rxs;
  logic [TW-1:0] tmr_q, tmr_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic          expired;

  logic          sipo_shift_q, sipo_shift_d;
  logic          sipo_bit_q, sipo_bit_d;
  logic          sipo_clr_q, sipo_clr_d;
  logic [7:0]    data_out_q, data_out_d;
  logic          rx_valid_q, rx_valid_d;
  logic          frame_err_q, frame_err_d;
  logic          overrun_err_q, overrun_err_d;

  // Flops reset to the idle level so a reset never looks like a start bit.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      sync_q <= 2'b11;
    end else begin
      sync_q <= {sync_q[0], rx_in_i};
    end
  end

  assign rxs     = sync_q[1];
  assign expired = (tmr_q == '0);

  always_comb begin
    state_d       = state_q;
    tmr_d         = tmr_q;
    bit_cnt_d     = bit_cnt_q;
    sipo_shift_d  = 1'b0;
    sipo_bit_d    = 1'b0;
    sipo_clr_d    = 1'b0;
    frame_err_d   = 1'b0;
    overrun_err_d = 1'b0;
    data_out_d    = data_out_q;
    rx_valid_d    = rx_valid_q;

    if (rx_valid_q && rx_ready_i) begin
      rx_valid_d = 1'b0;
    end

    case (state_q)
      S_IDLE: begin
        if (!rxs) begin
          tmr_d   = HALF_RELOAD;
          state_d = S_START;
        end
      end

      S_START: begin
        if (!expired) begin
          tmr_d = tmr_q - TW'(1);
        end else if (!rxs) begin
          sipo_clr_d = 1'b1;
          tmr_d      = FULL_RELOAD;
          bit_cnt_d  = 3'd0;
          state_d    = S_DATA;
        end else begin
          state_d = S_IDLE;
        end
      end

      S_DATA: begin
        if (!expired) begin
          tmr_d = tmr_q - TW'(1);
        end else begin
          sipo_shift_d = 1'b1;
          sipo_bit_d   = rxs;
          tmr_d        = FULL_RELOAD;
          bit_cnt_d    = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            state_d = S_STOP;
          end
        end
      end

      S_STOP: begin
        if (!expired) begin
          tmr_d = tmr_q - TW'(1);
        end else if (rxs) begin
          state_d = S_IDLE;
          // An accept in this same cycle frees the holding register.
          if (rx_valid_q && !rx_ready_i) begin
            overrun_err_d = 1'b1;
          end else begin
            data_out_d = sipo_q_i;
            rx_valid_d = 1'b1;
          end
        end else begin
          frame_err_d = 1'b1;
          state_d     = S_BREAK;
        end
      end

      S_BREAK: begin
        if (rxs) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q       <= S_IDLE;
      tmr_q         <= '0;
      bit_cnt_q     <= 3'd0;
      sipo_shift_q  <= 1'b0;
      sipo_bit_q    <= 1'b0;
      sipo_clr_q    <= 1'b0;
      data_out_q    <= 8'h00;
      rx_valid_q    <= 1'b0;
      frame_err_q   <= 1'b0;
      overrun_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      tmr_q         <= tmr_d;
      bit_cnt_q     <= bit_cnt_d;
      sipo_shift_q  <= sipo_shift_d;
      sipo_bit_q    <= sipo_bit_d;
      sipo_clr_q    <= sipo_clr_d;
      data_out_q    <= data_out_d;
      rx_valid_q    <= rx_valid_d;
      frame_err_q   <= frame_err_d;
      overrun_err_q <= overrun_err_d;
    end
  end

  assign sipo_shift_o  = sipo_shift_q;
  assign sipo_bit_o    = sipo_bit_q;
  assign sipo_clr_o    = sipo_clr_q;
  assign data_out_o    = data_out_q;
  assign rx_valid_o    = rx_valid_q;
  assign frame_err_o   = frame_err_q;
  assign overrun_err_o = overrun_err_q;
  assign busy_o        = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Bench for uart_rx_ctrl at 16 clocks per bit, with a behavioural SIPO
// register and queues of expected data bits and delivered bytes.
module tb_uart_rx_ctrl;
  localparam int CPB = 16;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       rx = 1'b1;
  logic       rx_ready = 1'b1;
  logic [7:0] sipo_model = 8'h00;
  logic       sipo_shift, sipo_bit, sipo_clr, rx_valid, frame_err, overrun_err, busy;
  logic [7:0] data_out;

  int errors = 0;
  int checks = 0;
  logic [7:0] exp_bytes[$];
  logic       exp_bits[$];

  int cyc = 0, n_shift = 0, n_clr = 0, n_vrise = 0, n_vhigh = 0, n_ferr = 0, n_oerr = 0;
  int last_shift_cyc = 0, vrise_cyc = 0, frame_shifts = 0;
  logic valid_prev = 1'b0;

  uart_rx_ctrl #(.CLKS_PER_BIT(CPB)) dut (
    .clk_i        (clk),
    .reset_ni     (reset_n),
    .rx_in_i      (rx),
    .sipo_q_i     (sipo_model),
    .sipo_shift_o (sipo_shift),
    .sipo_bit_o   (sipo_bit),
    .sipo_clr_o   (sipo_clr),
    .data_out_o   (data_out),
    .rx_valid_o   (rx_valid),
    .rx_ready_i   (rx_ready),
    .frame_err_o  (frame_err),
    .overrun_err_o(overrun_err),
    .busy_o       (busy)
  );

  always #5 clk = ~clk;

  // LSB-first shift register fed by the controller.
  always @(posedge clk) begin
    if (sipo_clr) sipo_model <= 8'h00;
    else if (sipo_shift) sipo_model <= {sipo_bit, sipo_model[7:1]};
  end

  // Monitor: scoreboard for shifted bits and delivered bytes, plus event counters.
  initial begin
    logic       eb;
    logic [7:0] ebyte;
    forever begin
      @(negedge clk);
      cyc++;
      if (sipo_clr) begin
        n_clr++;
        frame_shifts = 0;
      end
      if (sipo_shift) begin
        n_shift++;
        checks++;
        if (exp_bits.size() == 0) begin
          errors++;
          $display("FAIL shift_bit: unexpected shift of %0b, required no shift", sipo_bit);
        end else begin
          eb = exp_bits.pop_front();
          if (sipo_bit !== eb) begin
            errors++;
            $display("FAIL shift_bit: got %0b, required %0b", sipo_bit, eb);
          end
        end
        if (frame_shifts > 0) begin
          checks++;
          if (cyc - last_shift_cyc != CPB) begin
            errors++;
            $display("FAIL shift_spacing: got %0d clks, required %0d", cyc - last_shift_cyc, CPB);
          end
        end
        frame_shifts++;
        last_shift_cyc = cyc;
      end
      if (rx_valid && !valid_prev) begin
        n_vrise++;
        vrise_cyc = cyc;
      end
      if (rx_valid) n_vhigh++;
      valid_prev = rx_valid;
      if (frame_err) n_ferr++;
      if (overrun_err) n_oerr++;
      if (rx_valid && rx_ready) begin
        checks++;
        if (exp_bytes.size() == 0) begin
          errors++;
          $display("FAIL accept_byte: unexpected byte %02h, required none", data_out);
        end else begin
          ebyte = exp_bytes.pop_front();
          if (data_out !== ebyte) begin
            errors++;
            $display("FAIL accept_byte: got %02h, required %02h", data_out, ebyte);
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_bit, input logic ready_at_stop);
    for (int i = 0; i < 8; i++) exp_bits.push_back(b[i]);
    rx = 1'b0;
    ticks(CPB);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      ticks(CPB);
    end
    rx = stop_bit;
    for (int k = 0; k < CPB; k++) begin
      // k==10 is the cycle just before the stop-bit sampling edge.
      if (ready_at_stop && k == 10) rx_ready = 1'b1;
      tick();
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    rx = 1'b1;
    ticks(3);
    checks++; if (data_out !== 8'h00) begin errors++; $display("FAIL reset_data: got %02h, required 00", data_out); end
    checks++; if ({sipo_shift, sipo_bit, sipo_clr} !== 3'b000) begin errors++; $display("FAIL reset_sipo: got %03b, required 000", {sipo_shift, sipo_bit, sipo_clr}); end
    checks++; if ({rx_valid, frame_err, overrun_err, busy} !== 4'b0000) begin errors++; $display("FAIL reset_flags: got %04b, required 0000", {rx_valid, frame_err, overrun_err, busy}); end
    reset_n = 1'b1;
    ticks(3);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL idle_busy: got %0b, required 0", busy); end
  endtask

  task automatic test_good_frame();
    int s0 = n_shift, v0 = n_vrise, h0 = n_vhigh;
    rx_ready = 1'b1;
    exp_bytes.push_back(8'hA5);
    send_frame(8'hA5, 1'b1, 1'b0);
    ticks(4);
    checks++; if (n_shift - s0 != 8) begin errors++; $display("FAIL a5_shifts: got %0d, required 8", n_shift - s0); end
    checks++; if (n_vrise - v0 != 1) begin errors++; $display("FAIL a5_valid_rise: got %0d, required 1", n_vrise - v0); end
    checks++; if (n_vhigh - h0 != 1) begin errors++; $display("FAIL a5_valid_cycles: got %0d, required 1", n_vhigh - h0); end
    checks++; if (vrise_cyc - last_shift_cyc != CPB) begin errors++; $display("FAIL a5_valid_latency: got %0d, required %0d", vrise_cyc - last_shift_cyc, CPB); end
    checks++; if (data_out !== 8'hA5) begin errors++; $display("FAIL a5_data: got %02h, required a5", data_out); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL a5_busy: got %0b, required 0", busy); end
    checks++; if (exp_bytes.size() != 0) begin errors++; $display("FAIL a5_delivered: got %0d pending, required 0", exp_bytes.size()); end
  endtask

  task automatic test_glitch();
    int c0 = n_clr, s0 = n_shift, v0 = n_vrise;
    rx = 1'b0;
    ticks(4);
    rx = 1'b1;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL glitch_start: busy got %0b, required 1", busy); end
    ticks(20);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL glitch_idle: busy got %0b, required 0", busy); end
    checks++; if ({n_clr - c0, n_shift - s0, n_vrise - v0} != 96'd0) begin errors++; $display("FAIL glitch_events: clr=%0d shift=%0d valid=%0d, required 0 0 0", n_clr - c0, n_shift - s0, n_vrise - v0); end
  endtask

  task automatic test_frame_error();
    int f0 = n_ferr, v0 = n_vrise, c0 = n_clr;
    send_frame(8'h3C, 1'b0, 1'b0);
    ticks(30);
    checks++; if (n_ferr - f0 != 1) begin errors++; $display("FAIL ferr_pulse: got %0d cycles, required 1", n_ferr - f0); end
    checks++; if (n_vrise - v0 != 0 || rx_valid !== 1'b0) begin errors++; $display("FAIL ferr_valid: rises=%0d valid=%0b, required 0 0", n_vrise - v0, rx_valid); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL ferr_busy_low: got %0b, required 1", busy); end
    checks++; if (n_clr - c0 != 1) begin errors++; $display("FAIL ferr_break_quiet: clr got %0d, required 1", n_clr - c0); end
    rx = 1'b1;
    ticks(4);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ferr_busy_high: got %0b, required 0", busy); end
    ticks(16);
  endtask

  task automatic test_overrun();
    int o0 = n_oerr;
    rx_ready = 1'b0;
    exp_bytes.push_back(8'h11);
    send_frame(8'h11, 1'b1, 1'b0);
    ticks(4);
    send_frame(8'h22, 1'b1, 1'b0);
    ticks(4);
    checks++; if (n_oerr - o0 != 1) begin errors++; $display("FAIL ovr_pulse: got %0d, required 1", n_oerr - o0); end
    checks++; if (data_out !== 8'h11) begin errors++; $display("FAIL ovr_data: got %02h, required 11", data_out); end
    checks++; if (rx_valid !== 1'b1) begin errors++; $display("FAIL ovr_valid_held: got %0b, required 1", rx_valid); end
    rx_ready = 1'b1;
    ticks(3);
    checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL ovr_accept: valid got %0b, required 0", rx_valid); end
  endtask

  task automatic test_ready_on_stop();
    int o0 = n_oerr, v0 = n_vrise;
    rx_ready = 1'b0;
    exp_bytes.push_back(8'h33);
    send_frame(8'h33, 1'b1, 1'b0);
    ticks(4);
    exp_bytes.push_back(8'h44);
    send_frame(8'h44, 1'b1, 1'b1);
    checks++; if (data_out !== 8'h44) begin errors++; $display("FAIL same_cycle_data: got %02h, required 44", data_out); end
    checks++; if (n_oerr - o0 != 0) begin errors++; $display("FAIL same_cycle_overrun: got %0d, required 0", n_oerr - o0); end
    checks++; if (n_vrise - v0 != 1) begin errors++; $display("FAIL same_cycle_valid_rises: got %0d, required 1", n_vrise - v0); end
    ticks(3);
    checks++; if (exp_bytes.size() != 0) begin errors++; $display("FAIL same_cycle_delivered: got %0d pending, required 0", exp_bytes.size()); end
  endtask

  task automatic test_reset_mid_frame();
    int s0;
    rx_ready = 1'b1;
    rx = 1'b0;
    ticks(20);
    reset_n = 1'b0;
    #1;
    checks++; if (data_out !== 8'h00) begin errors++; $display("FAIL midreset_data: got %02h, required 00", data_out); end
    checks++; if ({busy, rx_valid, sipo_clr, sipo_shift} !== 4'b0000) begin errors++; $display("FAIL midreset_flags: got %04b, required 0000", {busy, rx_valid, sipo_clr, sipo_shift}); end
    rx = 1'b1;
    ticks(3);
    reset_n = 1'b1;
    ticks(20);
    s0 = n_shift;
    exp_bytes.push_back(8'h5A);
    send_frame(8'h5A, 1'b1, 1'b0);
    ticks(4);
    checks++; if (n_shift - s0 != 8) begin errors++; $display("FAIL post_reset_shifts: got %0d, required 8", n_shift - s0); end
    checks++; if (data_out !== 8'h5A) begin errors++; $display("FAIL post_reset_data: got %02h, required 5a", data_out); end
  endtask

  initial begin
    test_reset();
    test_good_frame();
    test_glitch();
    test_frame_error();
    test_overrun();
    test_ready_on_stop();
    test_reset_mid_frame();
    checks++;
    if (exp_bytes.size() != 0 || exp_bits.size() != 0) begin
      errors++;
      $display("FAIL drain: bytes=%0d bits=%0d pending, required 0 0", exp_bytes.size(), exp_bits.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
